// File: rtl/shift_deserializer_pkg.sv
// Shared state and bit-order encodings for the serial-to-parallel receiver.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input handshake, bit order/abort controls and word output handshake.
interface shift_deserializer_if #(parameter int WIDTH = 4);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic          SIN;
  logic          SIN_VALID;
  logic          SIN_READY;
  logic          DIR;
  logic          CLR;
  logic [WIDTH-1:0] Q;
  logic          Q_VALID;
  logic          Q_READY;
  logic [CW-1:0] BIT_CNT;

  modport master (
    output SIN, SIN_VALID, DIR, CLR, Q_READY,
    input  SIN_READY, Q, Q_VALID, BIT_CNT
  );

  modport slave (
    input  SIN, SIN_VALID, DIR, CLR, Q_READY,
    output SIN_READY, Q, Q_VALID, BIT_CNT
  );
endinterface

// File: rtl/shift_deserializer_core.sv
// Shift register, bit counter and per-word bit-order latch.
module shift_deser_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             take,
  input  logic             keep_cnt,
  input  logic             cnt_clr,
  input  logic             sin,
  input  logic             dir,
  output logic [WIDTH-1:0] shreg,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             order;
  logic             first;
  logic             eff_dir;
  logic [WIDTH-1:0] base;

  // The first bit of a word starts from a clean register and uses DIR live.
  always_comb begin
    first     = (bit_cnt == '0);
    eff_dir   = first ? dir : order;
    base      = first ? '0 : shreg;
    word      = (eff_dir == DIR_LSB_FIRST) ? {sin, base[WIDTH-1:1]}
                                           : {base[WIDTH-2:0], sin};
    word_done = take && (bit_cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      order   <= DIR_MSB_FIRST;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      shreg <= word;
      if (first)
        order <= dir;
      if (word_done)
        bit_cnt <= keep_cnt ? bit_cnt : '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: sequencing FSM plus one-entry output register.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic CLK,
  input logic RST,
  shift_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             sin_ready;
  logic             accept;
  logic             drain;
  logic             q_free;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] q;
  logic             q_valid;

  // CLR blocks the accept even when SIN_READY is high.
  assign accept = bus.SIN_VALID && sin_ready && !bus.CLR;
  assign drain  = q_valid && bus.Q_READY;
  assign q_free = !q_valid || bus.Q_READY;

  shift_deser_core #(.WIDTH(WIDTH)) u_core (
    .clk       (CLK),
    .rst       (RST),
    .clr       (bus.CLR),
    .take      (accept),
    .keep_cnt  (!q_free),
    .cnt_clr   ((state == HOLD) && drain),
    .sin       (bus.SIN),
    .dir       (bus.DIR),
    .shreg     (shreg),
    .word      (word),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.CLR) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = SHIFT;
        SHIFT:   if (word_done) state_next = q_free ? IDLE : HOLD;
        HOLD:    if (drain) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sin_ready = (state != HOLD);
  end

  // A HOLD word discarded by CLR must not be promoted by a same-cycle drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (word_done && q_free) begin
      q       <= word;
      q_valid <= 1'b1;
    end else if ((state == HOLD) && drain && !bus.CLR) begin
      q <= shreg;
    end else if (drain) begin
      q_valid <= 1'b0;
    end
  end

  assign bus.SIN_READY = sin_ready;
  assign bus.Q         = q;
  assign bus.Q_VALID   = q_valid;
  assign bus.BIT_CNT   = bit_cnt;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for the 4-bit serial-to-parallel receiver.
module tb_shift_deserializer;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  shift_deserializer_if #(.WIDTH(4)) bus ();

  shift_deserializer #(.WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic send_bit(input logic b);
    bus.SIN       = b;
    bus.SIN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.SIN_VALID = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #1;
    checks++; if (bus.Q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=%b", bus.Q, 4'b0000); end
    checks++; if (bus.Q_VALID !== 1'b0) begin failures++; $display("FAIL reset_qv got=%b exp=%b", bus.Q_VALID, 1'b0); end
    checks++; if (bus.BIT_CNT !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=%0d", bus.BIT_CNT, 0); end
    #5 RST = 1'b0;
    idle_cycle();
    checks++; if (bus.SIN_READY !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=%b", bus.SIN_READY, 1'b1); end
  endtask

  task automatic test_msb_first();
    bus.DIR = 1'b0;
    bus.Q_READY = 1'b1;
    send_bit(1'b1);
    checks++; if (bus.BIT_CNT !== 2'd1) begin failures++; $display("FAIL msb_cnt1 got=%0d exp=%0d", bus.BIT_CNT, 1); end
    send_bit(1'b0);
    send_bit(1'b1);
    checks++; if (bus.BIT_CNT !== 2'd3) begin failures++; $display("FAIL msb_cnt3 got=%0d exp=%0d", bus.BIT_CNT, 3); end
    checks++; if (bus.Q_VALID !== 1'b0) begin failures++; $display("FAIL msb_qv_early got=%b exp=%b", bus.Q_VALID, 1'b0); end
    send_bit(1'b1);
    checks++; if (bus.Q !== 4'b1011) begin failures++; $display("FAIL msb_q got=%b exp=%b", bus.Q, 4'b1011); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL msb_qv got=%b exp=%b", bus.Q_VALID, 1'b1); end
    checks++; if (bus.BIT_CNT !== 2'd0) begin failures++; $display("FAIL msb_cnt0 got=%0d exp=%0d", bus.BIT_CNT, 0); end
    idle_cycle();
    checks++; if (bus.Q_VALID !== 1'b0) begin failures++; $display("FAIL msb_drain got=%b exp=%b", bus.Q_VALID, 1'b0); end
    checks++; if (bus.Q !== 4'b1011) begin failures++; $display("FAIL msb_q_keep got=%b exp=%b", bus.Q, 4'b1011); end
  endtask

  task automatic test_lsb_first();
    bus.DIR = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (bus.Q !== 4'b1101) begin failures++; $display("FAIL lsb_q got=%b exp=%b", bus.Q, 4'b1101); end
    send_bit(1'b1);
    send_bit(1'b0);
    bus.DIR = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (bus.Q !== 4'b1101) begin failures++; $display("FAIL lsb_dir_latch got=%b exp=%b", bus.Q, 4'b1101); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL lsb_qv got=%b exp=%b", bus.Q_VALID, 1'b1); end
  endtask

  task automatic test_backpressure();
    bus.DIR = 1'b0;
    idle_cycle();
    bus.Q_READY = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    checks++; if (bus.Q !== 4'b1011) begin failures++; $display("FAIL bp_first got=%b exp=%b", bus.Q, 4'b1011); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    checks++; if (bus.SIN_READY !== 1'b0) begin failures++; $display("FAIL bp_hold_rdy got=%b exp=%b", bus.SIN_READY, 1'b0); end
    checks++; if (bus.Q !== 4'b1011) begin failures++; $display("FAIL bp_q_held got=%b exp=%b", bus.Q, 4'b1011); end
    bus.SIN = 1'b1;
    bus.SIN_VALID = 1'b1;
    idle_cycle();
    idle_cycle();
    checks++; if (bus.SIN_READY !== 1'b0) begin failures++; $display("FAIL bp_stall_rdy got=%b exp=%b", bus.SIN_READY, 1'b0); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL bp_stall_qv got=%b exp=%b", bus.Q_VALID, 1'b1); end
    bus.SIN_VALID = 1'b0;
    bus.Q_READY = 1'b1;
    idle_cycle();
    bus.Q_READY = 1'b0;
    checks++; if (bus.Q !== 4'b0110) begin failures++; $display("FAIL bp_release_q got=%b exp=%b", bus.Q, 4'b0110); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL bp_release_qv got=%b exp=%b", bus.Q_VALID, 1'b1); end
    checks++; if (bus.SIN_READY !== 1'b1) begin failures++; $display("FAIL bp_release_rdy got=%b exp=%b", bus.SIN_READY, 1'b1); end
    checks++; if (bus.BIT_CNT !== 2'd0) begin failures++; $display("FAIL bp_release_cnt got=%0d exp=%0d", bus.BIT_CNT, 0); end
  endtask

  task automatic test_back_to_back();
    bus.Q_READY = 1'b1;
    idle_cycle();
    checks++; if (bus.Q_VALID !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=%b", bus.Q_VALID, 1'b0); end
    bus.Q_READY = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    bus.Q_READY = 1'b1;
    send_bit(1'b1);
    bus.Q_READY = 1'b0;
    checks++; if (bus.Q !== 4'b0011) begin failures++; $display("FAIL b2b_q got=%b exp=%b", bus.Q, 4'b0011); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL b2b_qv got=%b exp=%b", bus.Q_VALID, 1'b1); end
    checks++; if (bus.SIN_READY !== 1'b1) begin failures++; $display("FAIL b2b_no_hold got=%b exp=%b", bus.SIN_READY, 1'b1); end
  endtask

  task automatic test_clr();
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (bus.BIT_CNT !== 2'd2) begin failures++; $display("FAIL clr_pre_cnt got=%0d exp=%0d", bus.BIT_CNT, 2); end
    bus.CLR = 1'b1;
    bus.SIN = 1'b1;
    bus.SIN_VALID = 1'b1;
    idle_cycle();
    bus.CLR = 1'b0;
    bus.SIN_VALID = 1'b0;
    checks++; if (bus.BIT_CNT !== 2'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=%0d", bus.BIT_CNT, 0); end
    checks++; if (bus.Q !== 4'b0011) begin failures++; $display("FAIL clr_q_kept got=%b exp=%b", bus.Q, 4'b0011); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL clr_qv_kept got=%b exp=%b", bus.Q_VALID, 1'b1); end
    bus.Q_READY = 1'b1;
    send_bit(1'b0);
    checks++; if (bus.BIT_CNT !== 2'd1) begin failures++; $display("FAIL clr_post_cnt got=%0d exp=%0d", bus.BIT_CNT, 1); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus.Q_READY = 1'b0;
    checks++; if (bus.Q !== 4'b0101) begin failures++; $display("FAIL clr_word got=%b exp=%b", bus.Q, 4'b0101); end
    checks++; if (bus.Q_VALID !== 1'b1) begin failures++; $display("FAIL clr_word_qv got=%b exp=%b", bus.Q_VALID, 1'b1); end
  endtask

  task automatic test_async_reset();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    checks++; if (bus.BIT_CNT !== 2'd3) begin failures++; $display("FAIL ar_pre_cnt got=%0d exp=%0d", bus.BIT_CNT, 3); end
    #2 RST = 1'b1;
    #1;
    checks++; if (bus.Q !== 4'b0000) begin failures++; $display("FAIL ar_q got=%b exp=%b", bus.Q, 4'b0000); end
    checks++; if (bus.Q_VALID !== 1'b0) begin failures++; $display("FAIL ar_qv got=%b exp=%b", bus.Q_VALID, 1'b0); end
    checks++; if (bus.BIT_CNT !== 2'd0) begin failures++; $display("FAIL ar_cnt got=%0d exp=%0d", bus.BIT_CNT, 0); end
    #1 RST = 1'b0;
    idle_cycle();
    checks++; if (bus.SIN_READY !== 1'b1) begin failures++; $display("FAIL ar_rdy got=%b exp=%b", bus.SIN_READY, 1'b1); end
    bus.Q_READY = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    checks++; if (bus.Q !== 4'b1001) begin failures++; $display("FAIL ar_word got=%b exp=%b", bus.Q, 4'b1001); end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    RST           = 1'b0;
    bus.SIN       = 1'b0;
    bus.SIN_VALID = 1'b0;
    bus.DIR       = 1'b0;
    bus.CLR       = 1'b0;
    bus.Q_READY   = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-to-parallel receiver. It is the receive end of the rotate/shift datapath used by the 4-bit SHIFTER. It accepts one bit per cycle under a valid/ready handshake and assembles WIDTH-bit words in MSB-first or LSB-first order. Completed words are presented through a one-entry output register with valid/ready backpressure to the downstream consumer.

Parameters:
WIDTH, 4, word width in bits (>= 2); bit counter width is derived as clog2(WIDTH).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  asynchronous, active-high reset.
SIN  input  1  serial data bit.
SIN_VALID  input  1  SIN carries a bit this cycle.
SIN_READY  output  1  block accepts a bit this cycle.
DIR  input  1  bit order. 0 = MSB-first: shift left, new bit enters bit 0. 1 = LSB-first: shift right, new bit enters bit WIDTH-1.
CLR  input  1  synchronous abort of the partially assembled word.
Q  output  WIDTH  assembled word.
Q_VALID  output  1  Q holds an unconsumed word.
Q_READY  input  1  consumer takes Q this cycle.
BIT_CNT  output  clog2(WIDTH)  number of bits accepted into the current partial word.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- RST asserted, with immediate effect:
  - state = IDLE, shift register = 0, BIT_CNT = 0.
  - Q = 0, Q_VALID = 0.
  - SIN_READY = 1 from the first cycle after RST deasserts.
- Accept events:
  - Bit accept = SIN_VALID && SIN_READY at a rising edge.
  - Output drain = Q_VALID && Q_READY at a rising edge.
- States:
  - IDLE: no partial word; BIT_CNT = 0.
  - SHIFT: 1..WIDTH-1 bits held.
  - HOLD: full word assembled, waiting for the output register.
- SIN_READY = (state != HOLD); this is combinational from state.
- DIR is latched into an internal order bit on the first accepted bit of each word (IDLE -> SHIFT). Changes to DIR mid-word are ignored.
- IDLE: on a bit accept, load the first bit, set BIT_CNT = 1, go to SHIFT. This path applies only when WIDTH >= 2.
- SHIFT, bit accept with BIT_CNT < WIDTH-1: shift in the bit, BIT_CNT += 1.
- SHIFT, bit accept with BIT_CNT = WIDTH-1 (last bit):
  - If the output register is empty (!Q_VALID), or is draining in the same cycle: Q <= completed word, Q_VALID <= 1, BIT_CNT <= 0, go to IDLE.
  - Otherwise: keep the completed word in the shift register, go to HOLD.
- HOLD: on an output drain, Q <= held word, Q_VALID stays 1, go to IDLE, BIT_CNT <= 0.
- Output drain with no new word completing: Q_VALID <= 0. Q keeps its last value.
- Latency: the last bit is accepted at edge N; Q/Q_VALID update at edge N, visible in cycle N+1. There is no bubble when the drain and the completion coincide.
- CLR (synchronous, highest priority below RST):
  - Shift register <= 0, BIT_CNT <= 0, state <= IDLE. This discards a HOLD word.
  - A bit offered in the same cycle is not accepted, even though SIN_READY may be high.
  - CLR does not affect Q or Q_VALID; a drain in the same cycle still clears Q_VALID.
- SIN_VALID while in HOLD: no accept and no state change; the producer must keep SIN stable.
- Q and Q_VALID are registered outputs. BIT_CNT is a direct register output.

Decomposition:
- Shared package shift_pkg holds:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2;
  - DIR encodings DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1.
- One natural sub-module, shift_deser_core: shift register, bit counter and order latch, with a "word_done" strobe.
- The top level holds the FSM and the output register.

Test Plan:
- WIDTH=4, DIR=0, Q_READY=1, SIN=1,0,1,1 on four consecutive accepts -> Q=4'b1011, Q_VALID=1 one cycle after the 4th edge, BIT_CNT=0.
- DIR=1, same bits -> Q=4'b1101. DIR toggled to 0 after the 2nd bit -> Q still 4'b1101.
- Q_READY=0, send 1011 then 0110 -> Q=1011 held; after the 8th bit state=HOLD, SIN_READY=0, further SIN_VALID ignored. Pulse Q_READY -> next cycle Q=0110, Q_VALID=1, SIN_READY=1.
- Q_VALID=1 with Q=1011, Q_READY=1 on the same edge as the last bit of 0011 -> Q=0011, Q_VALID stays 1, no HOLD entry.
- Send 1,1 then CLR=1 with SIN_VALID=1 -> BIT_CNT=0, bit not taken; then 0,1,0,1 -> Q=4'b0101.
- RST asserted asynchronously mid-cycle after 3 bits with Q_VALID=1 -> Q=0, Q_VALID=0, BIT_CNT=0 immediately; SIN_READY=1 after release.
